// File: rtl/usbdev_aon_wake_mp.sv
// Always-on USB suspend/wake monitor with one independent FSM per port.
// Line events are synchronised, filtered, then turned into sticky flags and a wake request.

module usbdev_aon_wake_filt #(
    parameter int Cycles = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    localparam int CntW = (Cycles > 0) ? $clog2(Cycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((Cycles > 0) ? Cycles - 1 : 0);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;

    // The output moves only once the synced value has differed from it for Cycles samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in};
            if (sync_q[1] == out) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                out   <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end
endmodule

module usbdev_aon_wake_mp #(
    parameter int NumPorts          = 1,
    parameter int IdleFilterCycles  = 4,
    parameter int ResetFilterCycles = 3,
    parameter int SenseFilterCycles = 3,
    parameter int ArmCycles         = 2,
    parameter int TimeoutCycles     = 1024
) (
    input  logic                  clk_aon_i,
    input  logic                  rst_aon_i,
    input  logic [NumPorts-1:0]   usb_dp_i,
    input  logic [NumPorts-1:0]   usb_dn_i,
    input  logic [NumPorts-1:0]   usb_sense_i,
    input  logic [NumPorts-1:0]   usbdev_dppullup_en_i,
    input  logic [NumPorts-1:0]   usbdev_dnpullup_en_i,
    input  logic [NumPorts-1:0]   suspend_req_aon_i,
    input  logic [NumPorts-1:0]   wake_ack_aon_i,
    input  logic [3*NumPorts-1:0] event_en_aon_i,
    output logic [NumPorts-1:0]   usb_dppullup_en_o,
    output logic [NumPorts-1:0]   usb_dnpullup_en_o,
    output logic [NumPorts-1:0]   wake_req_aon_o,
    output logic                  wake_req_any_aon_o,
    output logic [NumPorts-1:0]   bus_not_idle_aon_o,
    output logic [NumPorts-1:0]   bus_reset_aon_o,
    output logic [NumPorts-1:0]   sense_lost_aon_o,
    output logic [NumPorts-1:0]   wake_timeout_aon_o,
    output logic [NumPorts-1:0]   wake_detect_active_aon_o
);
    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, WAKE} state_e;

    localparam int ArmW = (ArmCycles > 0) ? $clog2(ArmCycles + 1) : 1;
    localparam logic [ArmW-1:0] ArmLast = ArmW'((ArmCycles > 0) ? ArmCycles - 1 : 0);
    localparam int ToW = $clog2(TimeoutCycles + 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TimeoutCycles);

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        state_e          state_q, state_d;
        logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
        logic [ToW-1:0]  to_cnt_q;
        logic            timeout_q;
        logic [2:0]      flags_q;
        logic [1:0]      dp_pu_sync_q, dn_pu_sync_q;
        logic            dp_pu_q, dn_pu_q;
        logic            not_idle_f, se0_f, lost_f;
        logic [2:0]      ev;
        logic            idle;

        assign idle = (state_q == IDLE);

        assign usb_dppullup_en_o[i] = idle ? usbdev_dppullup_en_i[i] : dp_pu_q;
        assign usb_dnpullup_en_o[i] = idle ? usbdev_dnpullup_en_i[i] : dn_pu_q;

        usbdev_aon_wake_filt #(.Cycles(IdleFilterCycles)) u_filt_idle (
            .clk (clk_aon_i),
            .rst (rst_aon_i),
            .in  ((usb_dp_i[i] != usb_dppullup_en_o[i]) | (usb_dn_i[i] != usb_dnpullup_en_o[i])),
            .out (not_idle_f)
        );

        usbdev_aon_wake_filt #(.Cycles(ResetFilterCycles)) u_filt_se0 (
            .clk (clk_aon_i),
            .rst (rst_aon_i),
            .in  (~usb_dp_i[i] & ~usb_dn_i[i]),
            .out (se0_f)
        );

        usbdev_aon_wake_filt #(.Cycles(SenseFilterCycles)) u_filt_lost (
            .clk (clk_aon_i),
            .rst (rst_aon_i),
            .in  (~usb_sense_i[i]),
            .out (lost_f)
        );

        assign ev = {lost_f, se0_f, not_idle_f};

        always_comb begin
            state_d   = state_q;
            arm_cnt_d = arm_cnt_q;
            case (state_q)
                IDLE: begin
                    if (suspend_req_aon_i[i]) begin
                        arm_cnt_d = '0;
                        if (ArmCycles == 0) state_d = ACTIVE;
                        else                state_d = ARM;
                    end
                end
                ARM: begin
                    if (wake_ack_aon_i[i])           state_d = IDLE;
                    else if (arm_cnt_q == ArmLast)   state_d = ACTIVE;
                    else                             arm_cnt_d = arm_cnt_q + ArmW'(1);
                end
                ACTIVE: begin
                    if (wake_ack_aon_i[i])                           state_d = IDLE;
                    else if (|(ev & event_en_aon_i[3*i +: 3]))       state_d = WAKE;
                end
                WAKE: begin
                    if (wake_ack_aon_i[i]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
            if (rst_aon_i) begin
                state_q      <= IDLE;
                arm_cnt_q    <= '0;
                to_cnt_q     <= '0;
                timeout_q    <= 1'b0;
                flags_q      <= '0;
                dp_pu_sync_q <= '0;
                dn_pu_sync_q <= '0;
                dp_pu_q      <= 1'b0;
                dn_pu_q      <= 1'b0;
            end else begin
                state_q      <= state_d;
                arm_cnt_q    <= arm_cnt_d;
                dp_pu_sync_q <= {dp_pu_sync_q[0], usbdev_dppullup_en_i[i]};
                dn_pu_sync_q <= {dn_pu_sync_q[0], usbdev_dnpullup_en_i[i]};
                if (idle) begin
                    dp_pu_q <= dp_pu_sync_q[1];
                    dn_pu_q <= dn_pu_sync_q[1];
                end
                // Flags and timeout clear only after a full cycle in IDLE, so they survive the ack edge.
                if (idle) begin
                    flags_q   <= '0;
                    to_cnt_q  <= '0;
                    timeout_q <= 1'b0;
                end else if (state_q != ARM) begin
                    flags_q <= flags_q | ev;
                    if (state_q == WAKE && to_cnt_q != ToMax) begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                        if (to_cnt_q == ToMax - ToW'(1)) timeout_q <= 1'b1;
                    end
                end
            end
        end

        assign wake_req_aon_o[i]           = (state_q == WAKE);
        assign wake_detect_active_aon_o[i] = ~idle;
        assign bus_not_idle_aon_o[i]       = flags_q[0];
        assign bus_reset_aon_o[i]          = flags_q[1];
        assign sense_lost_aon_o[i]         = flags_q[2];
        assign wake_timeout_aon_o[i]       = timeout_q;
    end

    assign wake_req_any_aon_o = |wake_req_aon_o;
endmodule

// File: tb/tb_usbdev_aon_wake_mp.sv
// Directed bench for the two-port AON wake monitor: a vector table for the main flow
// plus hand-written sequences for timeout, ack/event collision and mid-wake reset.

module tb_usbdev_aon_wake_mp;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dp, dn, sense, dppu, dnpu, susp, ack;
    logic [5:0] en;
    logic [1:0] dppu_o, dnpu_o, wake, ni, br, lost, tmo, act;
    logic       any;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    usbdev_aon_wake_mp #(
        .NumPorts(2), .IdleFilterCycles(4), .ResetFilterCycles(3),
        .SenseFilterCycles(3), .ArmCycles(2), .TimeoutCycles(8)
    ) dut (
        .clk_aon_i                (clk),
        .rst_aon_i                (rst),
        .usb_dp_i                 (dp),
        .usb_dn_i                 (dn),
        .usb_sense_i              (sense),
        .usbdev_dppullup_en_i     (dppu),
        .usbdev_dnpullup_en_i     (dnpu),
        .suspend_req_aon_i        (susp),
        .wake_ack_aon_i           (ack),
        .event_en_aon_i           (en),
        .usb_dppullup_en_o        (dppu_o),
        .usb_dnpullup_en_o        (dnpu_o),
        .wake_req_aon_o           (wake),
        .wake_req_any_aon_o       (any),
        .bus_not_idle_aon_o       (ni),
        .bus_reset_aon_o          (br),
        .sense_lost_aon_o         (lost),
        .wake_timeout_aon_o       (tmo),
        .wake_detect_active_aon_o (act)
    );

    typedef struct {
        string      name;
        logic [1:0] dp, dn, sense, dppu, dnpu, susp, ack;
        logic [5:0] en;
        int         cycles;
        logic [1:0] e_act, e_wake, e_ni, e_br, e_lost, e_to, e_dppu, e_dnpu;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    endtask

    task automatic chk_all(input string name, input logic [1:0] e_act, input logic [1:0] e_wake,
                           input logic [1:0] e_ni, input logic [1:0] e_br, input logic [1:0] e_lost,
                           input logic [1:0] e_to, input logic [1:0] e_dppu, input logic [1:0] e_dnpu);
        chk({name, ".active"}, act, e_act);
        chk({name, ".wake"}, wake, e_wake);
        chk({name, ".wake_any"}, {1'b0, any}, {1'b0, |e_wake});
        chk({name, ".not_idle"}, ni, e_ni);
        chk({name, ".bus_reset"}, br, e_br);
        chk({name, ".sense_lost"}, lost, e_lost);
        chk({name, ".timeout"}, tmo, e_to);
        chk({name, ".dppu"}, dppu_o, e_dppu);
        chk({name, ".dnpu"}, dnpu_o, e_dnpu);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           name         dp     dn     sense  dppu   dnpu   susp   ack    en         cyc act    wake   ni     br     lost   to     dppu_o dnpu_o
        vecs.push_back('{"idle",      2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"susp",      2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"arm_frz",   2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000001, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"to_active", 2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000001, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"k_filt",    2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000001, 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"k_wake",    2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000001, 1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"k_ack",     2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 6'b000001, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00});
        vecs.push_back('{"k_clr",     2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 6'b000001, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00});
        vecs.push_back('{"restore",   2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"se0_idle",  2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"se0_susp",  2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"se0_arm",   2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"se0_act",   2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"se0_flag",  2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"lost_filt", 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 5, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00});
        vecs.push_back('{"lost_flag", 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 6'b000000, 1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00});

        rst = 1'b1;
        dp = 2'b11; dn = 2'b00; sense = 2'b11; dppu = 2'b11; dnpu = 2'b00;
        susp = 2'b00; ack = 2'b00; en = 6'b000000;
        tick(3);
        chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        rst = 1'b0;

        foreach (vecs[k]) begin
            dp = vecs[k].dp; dn = vecs[k].dn; sense = vecs[k].sense;
            dppu = vecs[k].dppu; dnpu = vecs[k].dnpu;
            susp = vecs[k].susp; ack = vecs[k].ack; en = vecs[k].en;
            tick(vecs[k].cycles);
            chk_all(vecs[k].name, vecs[k].e_act, vecs[k].e_wake, vecs[k].e_ni, vecs[k].e_br,
                    vecs[k].e_lost, vecs[k].e_to, vecs[k].e_dppu, vecs[k].e_dnpu);
        end

        // Timeout: all three events are already filtered high; enabling sense_lost wakes next edge.
        en = 6'b000100;
        tick(1);
        chk("to.wake_rise", wake, 2'b01);
        chk("to.any_rise", {1'b0, any}, 2'b01);
        chk("to.start", tmo, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk($sformatf("to.edge%0d", k), tmo, (k == 8) ? 2'b01 : 2'b00);
            chk($sformatf("to.any%0d", k), {1'b0, any}, 2'b01);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk($sformatf("to.hold%0d", k), tmo, 2'b01);
            chk($sformatf("to.wake_hold%0d", k), wake, 2'b01);
        end
        ack = 2'b01;
        tick(1);
        chk("to.ack_tmo", tmo, 2'b01);
        chk("to.ack_wake", wake, 2'b00);
        chk("to.ack_act", act, 2'b00);
        ack = 2'b00;
        tick(1);
        chk("to.clr_tmo", tmo, 2'b00);
        chk("to.clr_lost", lost, 2'b00);

        // Ack arriving in the same cycle the filtered event is seen in ACTIVE.
        dp = 2'b11; dn = 2'b00; sense = 2'b11; en = 6'b000001;
        tick(8);
        susp = 2'b01;
        tick(1);
        susp = 2'b00;
        tick(2);
        chk("col.active", act, 2'b01);
        dp = 2'b10; dn = 2'b01;
        tick(6);
        chk("col.pre_wake", wake, 2'b00);
        chk("col.pre_act", act, 2'b01);
        ack = 2'b01;
        tick(1);
        chk("col.wake", wake, 2'b00);
        chk("col.act", act, 2'b00);
        ack = 2'b00;
        tick(1);
        chk("col.wake_after", wake, 2'b00);

        // Reset asserted mid-WAKE: everything drops at once, pull-ups pass through.
        susp = 2'b01;
        tick(1);
        susp = 2'b00;
        tick(3);
        chk("rst.wake", wake, 2'b01);
        dppu = 2'b01; dnpu = 2'b10;
        rst = 1'b1;
        #1;
        chk_all("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("rst.after_act", act, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
